alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a multi-cycle unsigned shift-add multiplier.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request channel; op, a, b are captured on accept
//   op                     000 add, 001 sub, 010 not a, 011 and, 100 or,
//                          101 xor, 110 signed lt, 111 unsigned mul
//   a, b                   operands
//   out_valid / out_ready  response channel
//   result, result_hi      result (low half for mul), high half of mul product
//   carry, overflow        carry-out (sub: 1 = no borrow); signed overflow,
//                          or nonzero high half for mul
//   zero, negative         derived from result only
//
// Single-cycle ops register their result straight from the request inputs.
// A mul spends WIDTH cycles in BUSY, one shift-add step per cycle. Results
// are held in DONE until out_ready, then kept (stale) through IDLE.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               c_q, c_d;
    logic               v_q, v_d;
    logic               z_q, z_d;
    logic               n_q, n_d;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // single-cycle datapath, fed directly from the request inputs
    logic [WIDTH:0]     sum_add, sum_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] acc_step;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + ONE;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'b000: begin
                alu_res = sum_add[MSB:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
            end
            3'b001: begin
                alu_res = sum_sub[MSB:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
            end
            3'b010:  alu_res = ~a;
            3'b011:  alu_res = a & b;
            3'b100:  alu_res = a | b;
            3'b101:  alu_res = a ^ b;
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;  // mul is handled by the sequencer
        endcase
    end

    // one shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        hi_d     = hi_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == 3'b111) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end else begin
                        res_d   = alu_res;
                        hi_d    = '0;
                        c_d     = alu_c;
                        v_d     = alu_v;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[MSB];
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // final step: publish the product taken from this step's sum
                if (cnt_q == LAST_STEP) begin
                    res_d   = acc_step[MSB:0];
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    c_d     = 1'b0;
                    v_d     = |acc_step[2*WIDTH-1:WIDTH];
                    z_d     = (acc_step[MSB:0] == '0);
                    n_d     = acc_step[MSB];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = hi_q;
    assign carry     = c_q;
    assign overflow  = v_q;
    assign zero      = z_q;
    assign negative  = n_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         carry, overflow, zero, negative;
    logic [2:0]   op;
    logic [W-1:0] a, b, result, result_hi;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference: plain integer arithmetic on the 4-bit operands.
    // packed as {hi[3:0], res[3:0], carry, overflow, zero, negative}
    function automatic logic [11:0] model(input logic [2:0] o, input int x, input int y);
        int sx, sy, r, h, c, v, t;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        r = 0; h = 0; c = 0; v = 0;
        case (o)
            3'd0: begin t = x + y; r = t % 16; c = int'(t >= 16);
                        v = int'((sx + sy) > 7 || (sx + sy) < -8); end
            3'd1: begin r = (x - y + 16) % 16; c = int'(x >= y);
                        v = int'((sx - sy) > 7 || (sx - sy) < -8); end
            3'd2: r = 15 - x;
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = int'(sx < sy);
            default: begin t = x * y; r = t % 16; h = t / 16; v = int'(h != 0); end
        endcase
        return {h[3:0], r[3:0], c[0], v[0], (r == 0), (r >= 8)};
    endfunction

    function automatic logic [11:0] outs();
        return {result_hi, result, carry, overflow, zero, negative};
    endfunction

    // Issue one op, scramble inputs after accept, optionally keep in_valid
    // up while busy, hold out_ready low for `hold` cycles, then handshake.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [3:0] x,
                         input logic [3:0] y, input int hold, input bit poke);
        logic [11:0] expv;
        int cyc;
        expv = model(o, int'(x), int'(y));
        check({tag, "_rdy"}, 32'(in_ready), 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = poke;
        op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (poke) check({tag, "_busy_rdy"}, 32'(in_ready), 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, cyc, (o == 3'd7) ? W + 1 : 1);
        check({tag, "_outs"}, 32'(outs()), 32'(expv));
        for (int i = 0; i < hold; i++) begin
            op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, 32'(out_valid), 1);
            check({tag, "_hold_outs"}, 32'(outs()), 32'(expv));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_hs_vld"}, 32'(out_valid), 0);
        check({tag, "_hs_rdy"}, 32'(in_ready), 1);
        check({tag, "_stale"}, 32'(outs()), 32'(expv));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rdy", 32'(in_ready), 1);
        check("reset_vld", 32'(out_valid), 0);
        check("reset_outs", 32'(outs()), 0);

        // directed
        do_op("add_wrap", 3'd0, 4'd7, 4'd9, 0, 1'b0);
        check("add_wrap_const", 32'(outs()), 32'({4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0}));
        do_op("add_ovf", 3'd0, 4'd7, 4'd1, 0, 1'b0);
        check("add_ovf_const", 32'(outs()), 32'({4'd0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1}));
        do_op("sub_borrow", 3'd1, 4'd3, 4'd5, 0, 1'b0);
        check("sub_borrow_const", 32'(outs()), 32'({4'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1}));
        do_op("lt_neg", 3'd6, 4'b1000, 4'd1, 0, 1'b0);
        check("lt_neg_const", 32'(result), 1);
        do_op("mul_max", 3'd7, 4'd15, 4'd15, 0, 1'b1);
        check("mul_max_const", 32'(outs()), 32'({4'b1110, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0}));
        do_op("backpressure", 3'd5, 4'd12, 4'd10, 3, 1'b0);

        // reset on the 2nd BUSY cycle of 9*11
        op = 3'd7; a = 4'd9; b = 4'd11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_rdy", 32'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rdy", 32'(in_ready), 1);
        check("abort_vld", 32'(out_valid), 0);
        check("abort_outs", 32'(outs()), 0);
        do_op("after_abort", 3'd0, 4'd1, 4'd1, 0, 1'b0);
        check("after_abort_res", 32'(result), 2);

        // randomized
        for (int n = 0; n < 40; n++) begin
            do_op("rand", 3'($urandom_range(7, 0)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
